// File: rtl/uart_rx.sv
// 8N1 UART receiver peripheral.
// The RX pin is synchronised, deserialised by a mid-bit sampling state
// machine and queued in a small byte FIFO. The CPU reads the FIFO head at
// offset 0x00, popping it with RDb, and reads FIFO status plus sticky
// error flags at offset 0x01. Writing 1s to the error bits at 0x01 clears
// them. All read data is registered, giving a one-cycle read latency.

module uart_rx #(
   parameter int CLK_FREQ   = 10_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int BITS       = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [7:0]      ADDRESS,
   input  logic [BITS-1:0] DATA_IN,
   output logic [BITS-1:0] DATA_OUT,
   input  logic            WRb,
   input  logic            RDb,
   input  logic            RX
);

   localparam int DIVISOR = CLK_FREQ / BAUD_RATE;
   localparam int HALF    = DIVISOR / 2;
   localparam int CW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam int PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int NW      = PW + 1;

   localparam logic [CW-1:0] DIV_LAST  = CW'(DIVISOR - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
   localparam logic [NW-1:0] FULL_CNT  = NW'(FIFO_DEPTH);

   localparam logic [7:0] ADDR_DATA   = 8'h00;
   localparam logic [7:0] ADDR_STATUS = 8'h01;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } state_t;

   // synchroniser and arming
   logic       sync1_r;
   logic       sync2_r;
   logic       rxs_s;
   logic [1:0] vld_r;
   logic       armed_r;

   // receive state machine
   state_t          state_r;
   state_t          state_s;
   logic [CW-1:0]   cnt_r;
   logic [CW-1:0]   cnt_s;
   logic [2:0]      bit_r;
   logic [2:0]      bit_s;
   logic [7:0]      shift_r;
   logic [7:0]      shift_s;
   logic            push_s;
   logic            frame_set_s;

   // FIFO
   logic [7:0]      mem_r [FIFO_DEPTH];
   logic [PW-1:0]   head_r;
   logic [PW-1:0]   tail_r;
   logic [NW-1:0]   count_r;
   logic [NW-1:0]   count_s;
   logic            empty_s;
   logic            full_s;
   logic            pop_s;
   logic            push_ok_s;
   logic            ovr_set_s;

   // status and bus
   logic            overrun_r;
   logic            frame_err_r;
   logic            status_wr_s;
   logic            clr_ovr_s;
   logic            clr_frm_s;
   logic [7:0]      status_s;
   logic [BITS-1:0] rdata_s;
   logic            unused_s;

   assign rxs_s = sync2_r;

   // Bring RX into the clock domain; arm reception only after the line has
   // been seen idle with real samples, so a frame already in progress when
   // reset is released is not mistaken for a start bit.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
         vld_r   <= 2'b00;
         armed_r <= 1'b0;
      end else begin
         sync1_r <= RX;
         sync2_r <= sync1_r;
         vld_r   <= {vld_r[0], 1'b1};
         if (vld_r[1] && sync2_r) begin
            armed_r <= 1'b1;
         end
      end
   end

   // Receive state, baud counter, bit index and shift register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
         bit_r   <= 3'd0;
         shift_r <= 8'h00;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         bit_r   <= bit_s;
         shift_r <= shift_s;
      end
   end

   // Next-state logic: start bit checked at its midpoint, then every bit
   // sampled one full bit period later; the counter restarts on every
   // transition and after each data sample.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r + CW'(1);
      bit_s       = bit_r;
      shift_s     = shift_r;
      push_s      = 1'b0;
      frame_set_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            cnt_s = '0;
            if (armed_r && !rxs_s) begin
               state_s = ST_START;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (cnt_r == HALF_LAST) begin
               cnt_s = '0;
               if (!rxs_s) begin
                  state_s = ST_DATA;
                  bit_s   = 3'd0;
               end else begin
                  state_s = ST_IDLE;
               end
            end else begin
               state_s = ST_START;
            end
         end
         ST_DATA: begin
            if (cnt_r == DIV_LAST) begin
               cnt_s   = '0;
               shift_s = {rxs_s, shift_r[7:1]};
               if (bit_r == 3'd7) begin
                  state_s = ST_STOP;
               end else begin
                  bit_s   = bit_r + 3'd1;
                  state_s = ST_DATA;
               end
            end else begin
               state_s = ST_DATA;
            end
         end
         ST_STOP: begin
            if (cnt_r == DIV_LAST) begin
               cnt_s = '0;
               if (rxs_s) begin
                  push_s  = 1'b1;
                  state_s = ST_IDLE;
               end else begin
                  frame_set_s = 1'b1;
                  state_s     = ST_BREAK;
               end
            end else begin
               state_s = ST_STOP;
            end
         end
         ST_BREAK: begin
            cnt_s = '0;
            if (rxs_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_BREAK;
            end
         end
         default: begin
            cnt_s   = '0;
            state_s = ST_IDLE;
         end
      endcase
   end

   // FIFO control: a pop in the same cycle frees a slot for a push into a
   // full FIFO; a pop of an empty FIFO is ignored.
   always_comb begin
      empty_s   = (count_r == '0);
      full_s    = (count_r == FULL_CNT);
      pop_s     = !RDb && (ADDRESS == ADDR_DATA) && !empty_s;
      push_ok_s = push_s && (!full_s || pop_s);
      ovr_set_s = push_s && full_s && !pop_s;
      case ({push_ok_s, pop_s})
         2'b10:   count_s = count_r + NW'(1);
         2'b01:   count_s = count_r - NW'(1);
         default: count_s = count_r;
      endcase
   end

   // FIFO pointers and occupancy; reset flushes the queue.
   always_ff @(posedge CLK) begin
      if (RST) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
      end else begin
         if (push_ok_s) begin
            tail_r <= tail_r + PW'(1);
         end
         if (pop_s) begin
            head_r <= head_r + PW'(1);
         end
         count_r <= count_s;
      end
   end

   // FIFO storage; contents need no reset since occupancy gates every read.
   always_ff @(posedge CLK) begin
      if (push_ok_s && !RST) begin
         mem_r[tail_r] <= shift_r;
      end
   end

   // Write-1-to-clear decode for the sticky error flags.
   always_comb begin
      status_wr_s = !WRb && (ADDRESS == ADDR_STATUS);
      if (status_wr_s) begin
         clr_ovr_s = DATA_IN[2];
         clr_frm_s = DATA_IN[3];
      end else begin
         clr_ovr_s = 1'b0;
         clr_frm_s = 1'b0;
      end
   end

   // Sticky error flags; a set in the same cycle as a clear wins.
   always_ff @(posedge CLK) begin
      if (RST) begin
         overrun_r   <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         overrun_r   <= ovr_set_s   | (overrun_r   & ~clr_ovr_s);
         frame_err_r <= frame_set_s | (frame_err_r & ~clr_frm_s);
      end
   end

   // Read mux: FIFO head at DATA, flags and occupancy at STATUS, zero elsewhere.
   always_comb begin
      status_s = {4'(count_r), frame_err_r, overrun_r, full_s, !empty_s};
      rdata_s  = '0;
      case (ADDRESS)
         ADDR_DATA: begin
            if (!empty_s) begin
               rdata_s[7:0] = mem_r[head_r];
            end else begin
               rdata_s[7:0] = 8'h00;
            end
         end
         ADDR_STATUS: begin
            rdata_s[7:0] = status_s;
         end
         default: begin
            rdata_s = '0;
         end
      endcase
   end

   // Registered read data; captures the pre-pop head on a DATA pop.
   always_ff @(posedge CLK) begin
      if (RST) begin
         DATA_OUT <= '0;
      end else begin
         DATA_OUT <= rdata_s;
      end
   end

   // Write data bits with no register behind them.
   assign unused_s = ^{DATA_IN[BITS-1:4], DATA_IN[1:0]};

endmodule
